core_result_sink: RTL and testbench

Peripheral-side endpoint of the core's result-reporting link. It captures every `to_peripheral_valid` pulse the core emits when a saved register (s1–s9) is written, and buffers the 2-bit tag plus 32-bit value in a first-word-fall-through FIFO for a host-side reader. For every pulse it returns a one-cycle ACK or DROP status on the core's `from_peripheral` inputs. It also keeps a running accepted-word count and a saturating overflow count.

---
 rtl/core_result_sink_pkg.sv | 19 +
 rtl/core_result_sink_if.sv | 22 ++
 rtl/core_result_sink_result_fifo.sv | 61 ++++++
 rtl/core_result_sink.sv | 125 ++++++++++++
 tb/tb_core_result_sink.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_result_sink_pkg.sv
// Shared definitions for the core result sink: response codes and entry packing.
package core_result_sink_pkg;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'b00,
      RSP_ACK  = 2'b01,
      RSP_DROP = 2'b10
   } rsp_e;

   localparam int unsigned TAG_BITS = 2;
   localparam int unsigned TS_BITS  = 32;
   localparam int unsigned CNT_BITS = 32;

   // Width of one buffered {tag, data} entry, timestamp excluded.
   function automatic int unsigned entry_bits(input int unsigned data_width);
      return TAG_BITS + data_width;
   endfunction

endpackage

// File: rtl/core_result_sink_if.sv
// Core <-> peripheral result-reporting link: capture strobe out of the core,
// one-cycle ACK/DROP response back into it.
interface core_result_sink_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [1:0]            to_peripheral;
   logic [DATA_WIDTH-1:0] to_peripheral_data;
   logic                  to_peripheral_valid;
   logic [1:0]            from_peripheral;
   logic [31:0]           from_peripheral_data;
   logic                  from_peripheral_valid;

   modport master (
      output to_peripheral, to_peripheral_data, to_peripheral_valid,
      input  from_peripheral, from_peripheral_data, from_peripheral_valid
   );

   modport slave (
      input  to_peripheral, to_peripheral_data, to_peripheral_valid,
      output from_peripheral, from_peripheral_data, from_peripheral_valid
   );
endinterface

// File: rtl/core_result_sink_result_fifo.sv
// First-word-fall-through FIFO with synchronous flush. The head entry is read
// combinationally from the array; push and pop may occur together when full.
module result_fifo #(
   parameter int unsigned WIDTH      = 34,
   parameter int unsigned DEPTH_BITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_flush,
   input  logic [WIDTH-1:0]      i_wdata,
   output logic [WIDTH-1:0]      o_rdata,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_BITS:0]   o_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_BITS;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_full    = (r_count == (DEPTH_BITS+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
   assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

   // Storage array: written at the tail on every accepted push.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointer and occupancy tracking; flush outranks push and pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/core_result_sink.sv
// Result sink top: captures core result strobes into a FWFT FIFO for the host,
// answers each strobe with ACK/DROP, and keeps word and overflow counters.
// Optional feature macro: CORE_RESULT_SINK_TIMESTAMP_EN (per-entry capture cycle).
module core_result_sink
   import core_result_sink_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_BITS = 3,
   parameter int unsigned OVF_BITS   = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   core_result_sink_if.slave     link,
   output logic                  host_valid,
   input  logic                  host_ready,
   output logic [1:0]            host_tag,
   output logic [DATA_WIDTH-1:0] host_data,
   output logic [31:0]           host_timestamp,
   input  logic                  flush,
   output logic [DEPTH_BITS:0]   fifo_count,
   output logic [OVF_BITS-1:0]   overflow_count
);

   localparam int unsigned BASE_W = entry_bits(DATA_WIDTH);
`ifdef CORE_RESULT_SINK_TIMESTAMP_EN
   localparam int unsigned ENTRY_W = BASE_W + TS_BITS;
`else
   localparam int unsigned ENTRY_W = BASE_W;
`endif

   logic [ENTRY_W-1:0]  w_wdata;
   logic [ENTRY_W-1:0]  w_rdata;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic [CNT_BITS-1:0] w_word_next;
   logic [CNT_BITS-1:0] r_word_cnt;
   logic [OVF_BITS-1:0] r_ovf_cnt;
   logic                r_rsp_valid;
   rsp_e                r_rsp_code;
   logic [CNT_BITS-1:0] r_rsp_data;

   // A full FIFO still accepts when the head leaves in the same cycle;
   // flush swallows any same-cycle strobe without counting it as overflow.
   assign w_pop       = host_valid & host_ready;
   assign w_push      = link.to_peripheral_valid & ~flush & (~w_full | w_pop);
   assign w_drop      = link.to_peripheral_valid & ~flush & w_full & ~w_pop;
   assign w_word_next = r_word_cnt + CNT_BITS'(1);

`ifdef CORE_RESULT_SINK_TIMESTAMP_EN
   logic [TS_BITS-1:0] r_cycle;

   // Free-running capture-cycle counter, wraps naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_cycle <= '0;
      else       r_cycle <= r_cycle + TS_BITS'(1);
   end

   assign w_wdata        = {r_cycle, link.to_peripheral, link.to_peripheral_data};
   assign host_timestamp = w_rdata[ENTRY_W-1 -: TS_BITS];
`else
   assign w_wdata        = {link.to_peripheral, link.to_peripheral_data};
   assign host_timestamp = '0;
`endif

   assign host_valid = ~w_empty;
   assign host_tag   = w_rdata[BASE_W-1 -: TAG_BITS];
   assign host_data  = w_rdata[DATA_WIDTH-1:0];

   result_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (flush),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   // Accepted-word counter, wraps at 2**32.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       r_word_cnt <= '0;
      else if (w_push) r_word_cnt <= w_word_next;
   end

   // Overflow counter, saturating at all-ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                           r_ovf_cnt <= '0;
      else if (w_drop && r_ovf_cnt != '1)  r_ovf_cnt <= r_ovf_cnt + OVF_BITS'(1);
   end

   // One response per strobe, presented in the cycle after capture.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_code  <= RSP_IDLE;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= link.to_peripheral_valid;
         if (w_push) begin
            r_rsp_code <= RSP_ACK;
            r_rsp_data <= w_word_next;
         end else if (link.to_peripheral_valid) begin
            r_rsp_code <= RSP_DROP;
            r_rsp_data <= r_word_cnt;
         end else begin
            r_rsp_code <= RSP_IDLE;
         end
      end
   end

   assign link.from_peripheral       = r_rsp_code;
   assign link.from_peripheral_data  = r_rsp_data;
   assign link.from_peripheral_valid = r_rsp_valid;
   assign overflow_count             = r_ovf_cnt;

endmodule

// File: tb/tb_core_result_sink.sv
// Self-checking bench for core_result_sink: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_core_result_sink;

   logic        clock;
   logic        reset;
   logic        host_valid;
   logic        host_ready;
   logic [1:0]  host_tag;
   logic [31:0] host_data;
   logic [31:0] host_timestamp;
   logic        flush;
   logic [3:0]  fifo_count;
   logic [15:0] overflow_count;

   core_result_sink_if #(.DATA_WIDTH(32)) link();

   core_result_sink #(
      .DATA_WIDTH (32),
      .DEPTH_BITS (3),
      .OVF_BITS   (16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .link           (link),
      .host_valid     (host_valid),
      .host_ready     (host_ready),
      .host_tag       (host_tag),
      .host_data      (host_data),
      .host_timestamp (host_timestamp),
      .flush          (flush),
      .fifo_count     (fifo_count),
      .overflow_count (overflow_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  tag;
      logic [31:0] data;
      logic [31:0] ts;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_wc;
   logic [15:0] m_ovf;
   logic        m_rv;
   logic [1:0]  m_rc;
   logic [31:0] m_rd;
   logic [31:0] cyc;
   int          n_popped;

   task automatic model_clear();
      q.delete();
      m_wc = 0; m_ovf = 0; m_rv = 0; m_rc = 0; m_rd = 0; cyc = 0; n_popped = 0;
   endtask

   // One clock: check head before the edge, advance model, check after the edge.
   task automatic tick();
      bit   pop, full;
      ent_t e;
      if (q.size() != 0) begin
         chk("host_valid", host_valid, 1);
         chk("host_tag", host_tag, q[0].tag);
         chk("host_data", host_data, q[0].data);
         chk("host_ts", host_timestamp, q[0].ts);
      end else begin
         chk("host_valid_empty", host_valid, 0);
      end
      pop  = (q.size() != 0) && host_ready;
      full = (q.size() == 8);
      m_rv = 0; m_rc = 2'b00;
      if (flush) begin
         q.delete();
         if (link.to_peripheral_valid) begin m_rv = 1; m_rc = 2'b10; m_rd = m_wc; end
      end else begin
         if (pop) begin void'(q.pop_front()); n_popped++; end
         if (link.to_peripheral_valid) begin
            m_rv = 1;
            if (!full || pop) begin
               e.tag  = link.to_peripheral;
               e.data = link.to_peripheral_data;
`ifdef CORE_RESULT_SINK_TIMESTAMP_EN
               e.ts = cyc;
`else
               e.ts = 0;
`endif
               q.push_back(e);
               m_wc = m_wc + 1;
               m_rc = 2'b01; m_rd = m_wc;
            end else begin
               if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 1;
               m_rc = 2'b10; m_rd = m_wc;
            end
         end
      end
      cyc = cyc + 1;
      @(posedge clock); #1;
      chk("rsp_valid", link.from_peripheral_valid, m_rv);
      chk("rsp_code", link.from_peripheral, m_rc);
      chk("rsp_data", link.from_peripheral_data, m_rd);
      chk("fifo_count", fifo_count, q.size());
      chk("overflow_count", overflow_count, m_ovf);
   endtask

   task automatic drive(input bit v, input logic [1:0] tag, input logic [31:0] d,
                        input bit rdy, input bit fl);
      link.to_peripheral_valid = v;
      link.to_peripheral       = tag;
      link.to_peripheral_data  = d;
      host_ready               = rdy;
      flush                    = fl;
   endtask

   // Called at posedge+1; asserts reset asynchronously, releases it at the next posedge+1.
   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("rst_host_valid", host_valid, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_rsp_valid", link.from_peripheral_valid, 0);
      chk("rst_rsp_code", link.from_peripheral, 0);
      chk("rst_rsp_data", link.from_peripheral_data, 0);
      chk("rst_ovf", overflow_count, 0);
      chk("rst_ts", host_timestamp, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      model_clear();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          rst;
      bit          v;
      logic [1:0]  tag;
      logic [31:0] data;
      bit          rdy;
      bit          fl;
      bit          hchk;
      logic [31:0] head;
      bit          ev;
      logic [1:0]  ec;
      logic [31:0] ed;
      int          efc;
      logic [15:0] eovf;
   } vec_t;

   function automatic vec_t mk(bit rst, bit v, logic [1:0] tag, logic [31:0] data,
                               bit rdy, bit fl, bit hchk, logic [31:0] head,
                               bit ev, logic [1:0] ec, logic [31:0] ed, int efc,
                               logic [15:0] eovf);
      vec_t r;
      r.rst = rst; r.v = v; r.tag = tag; r.data = data; r.rdy = rdy; r.fl = fl;
      r.hchk = hchk; r.head = head; r.ev = ev; r.ec = ec; r.ed = ed;
      r.efc = efc; r.eovf = eovf;
      return r;
   endfunction

   vec_t tbl[$];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] heads [8];
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      model_clear();
      @(posedge clock); #1;

      // Single strobe then pop.
      tbl.push_back(mk(1, 1, 0, 32'h1234, 0, 0, 0, 0, 1, 2'b01, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h1234, 0, 2'b00, 1, 0, 0));
      // Nine back-to-back strobes into an 8-deep FIFO.
      for (int i = 1; i <= 9; i++)
         tbl.push_back(mk(i == 1, 1, 2'(i % 4), 32'(i), 0, 0, 0, 0, 1,
                          (i <= 8) ? 2'b01 : 2'b10, 32'((i <= 8) ? i : 8),
                          (i <= 8) ? i : 8, 16'(i == 9)));
      // Full plus same-cycle pop accepts the new word.
      tbl.push_back(mk(0, 1, 3, 32'hAA, 1, 0, 1, 1, 1, 2'b01, 9, 8, 1));
      // Drain: 2..8 then 0xAA.
      for (int k = 0; k < 7; k++) heads[k] = 32'(k + 2);
      heads[7] = 32'hAA;
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, heads[k], 0, 2'b00, 9, 7 - k, 1));
      // Flush with strobe while holding 5 entries.
      for (int i = 1; i <= 5; i++)
         tbl.push_back(mk(i == 1, 1, 1, 32'h100 + 32'(i), 0, 0, 0, 0, 1, 2'b01,
                          32'(i), i, 0));
      tbl.push_back(mk(0, 1, 2, 32'hDEAD, 0, 1, 0, 0, 1, 2'b10, 5, 0, 0));
      tbl.push_back(mk(0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 1, 2'b01, 6, 1, 0));

      foreach (tbl[n]) begin
         if (tbl[n].rst) do_reset();
         drive(tbl[n].v, tbl[n].tag, tbl[n].data, tbl[n].rdy, tbl[n].fl);
         if (tbl[n].hchk) chk("tbl_head", host_data, tbl[n].head);
         tick();
         chk("tbl_rsp_valid", link.from_peripheral_valid, tbl[n].ev);
         chk("tbl_rsp_code", link.from_peripheral, tbl[n].ec);
         chk("tbl_rsp_data", link.from_peripheral_data, tbl[n].ed);
         chk("tbl_fifo_count", fifo_count, tbl[n].efc);
         chk("tbl_ovf", overflow_count, tbl[n].eovf);
      end

      // 20 strobes with host_ready toggling every cycle; no word may be lost.
      do_reset();
      for (int c = 0; c < 40; c++) begin
         drive(c % 2 == 0, 2'(c), 32'(c / 2 + 1), c % 2 == 1, 0);
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 0, 1, 0);
         tick();
      end
      chk("stream_popped", n_popped, 20);
      chk("stream_ovf", overflow_count, 0);
      chk("stream_words", link.from_peripheral_data, 20);

      // Randomized traffic including drops and occasional flushes.
      for (int c = 0; c < 600; c++) begin
         drive(($urandom % 4) != 0, 2'($urandom), $urandom, ($urandom % 3) == 0,
               ($urandom % 40) == 0);
         tick();
      end

      // Reset mid-stream discards buffered entries and the pending response.
      for (int c = 0; c < 3; c++) begin
         drive(1, 1, 32'h500 + 32'(c), 0, 0);
         tick();
      end
      do_reset();
      drive(0, 0, 0, 0, 0);
      tick();

      // Timestamps: strobes at edges 10 and 13 after reset release.
      do_reset();
      for (int e = 0; e < 14; e++) begin
         drive(e == 10 || e == 13, 0, 32'(e), 0, 0);
         tick();
      end
      drive(0, 0, 0, 1, 0);
`ifdef CORE_RESULT_SINK_TIMESTAMP_EN
      chk("ts_first", host_timestamp, 10);
`else
      chk("ts_first", host_timestamp, 0);
`endif
      tick();
`ifdef CORE_RESULT_SINK_TIMESTAMP_EN
      chk("ts_second", host_timestamp, 13);
`else
      chk("ts_second", host_timestamp, 0);
`endif
      drive(0, 0, 0, 1, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
